// File: rtl/debug_dump_sequencer_if.sv
// Tagged debug stream: FIFO head toward the MicroBlaze link.
interface debug_dump_sequencer_if #(
  parameter int NB_FRAME = 32,
  parameter int NB_SEL   = 6
);
  logic [NB_FRAME-1:0] data;
  logic [NB_SEL-1:0]   tag;
  logic                last;
  logic                data_valid;
  logic                data_ready;

  modport master (
    output data, tag, last, data_valid,
    input  data_ready
  );

  modport slave (
    input  data, tag, last, data_valid,
    output data_ready
  );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Debug snapshot sequencer: freezes the core, walks the debug sources
// and streams each source's word burst with tag and last markers.
module debug_dump_sequencer #(
  parameter int NB_FRAME   = 32,
  parameter int NB_SEL     = 6,
  parameter int MAX_WORDS  = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int DRAIN_MAX  = 15
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [2:0]             i_src_mask,
  output logic [NB_SEL-1:0]      o_select,
  input  logic [NB_FRAME-1:0]    i_frame,
  input  logic                   i_eod,
  output logic                   o_halt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  debug_dump_sequencer_if.master stream
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(MAX_WORDS + 1);
  localparam int DW  = $clog2(DRAIN_MAX + 1);
  localparam int LIM = FIFO_DEPTH - MAX_WORDS - 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_SPACE, ISSUE, CAPTURE, DRAIN, FLUSH
  } state_t;

  state_t state, state_d;

  logic [5:0]          idx;
  logic [2:0]          mask_q;
  logic                pend_v;
  logic [NB_FRAME-1:0] pend_d;
  logic [CW-1:0]       wcnt;
  logic [DW-1:0]       dcnt;
  logic                err_q;

  logic [NB_FRAME-1:0] mem_d [FIFO_DEPTH];
  logic [NB_SEL-1:0]   mem_t [FIFO_DEPTH];
  logic                mem_l [FIFO_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [AW:0]         cnt;

  logic [NB_SEL-1:0] cur_id, sel;
  logic [6:0]        first, nxt;
  logic              done, push, push_l, pop, valid;
  logic              ld_first, ld_pend, clr_pend;
  logic              wclr, winc, dclr, dinc, adv, set_err;

  // Source index 0..40: GPR 0..31, PC at 32, latch groups at 33..40.
  function automatic logic [6:0] seek(
    input logic [5:0] c,
    input logic [2:0] m
  );
    logic [6:0] r;
    r = '0;
    if (c <= 6'd31 && m[0])
      r = {1'b1, c};
    else if (c <= 6'd32 && m[1])
      r = {1'b1, 6'd32};
    else if (c <= 6'd40 && m[2])
      r = {1'b1, (c < 6'd33) ? 6'd33 : c};
    return r;
  endfunction

  always_comb begin
    if (idx < 6'd32)
      cur_id = NB_SEL'(idx);
    else if (idx == 6'd32)
      cur_id = NB_SEL'(6'd34);
    else
      cur_id = NB_SEL'(idx + 6'd3);
  end

  assign first = seek(6'd0, i_src_mask);
  assign nxt   = seek(idx + 6'd1, mask_q);

  always_ff @(posedge i_clock) begin
    if (i_reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    sel      = '1;
    done     = 1'b0;
    push     = 1'b0;
    push_l   = 1'b0;
    ld_first = 1'b0;
    ld_pend  = 1'b0;
    clr_pend = 1'b0;
    wclr     = 1'b0;
    winc     = 1'b0;
    dclr     = 1'b0;
    dinc     = 1'b0;
    adv      = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          ld_first = 1'b1;
          state_d  = first[6] ? WAIT_SPACE : FLUSH;
        end
      end
      WAIT_SPACE: begin
        if (int'(cnt) <= LIM)
          state_d = ISSUE;
      end
      ISSUE: begin
        sel      = cur_id;
        wclr     = 1'b1;
        clr_pend = 1'b1;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        push = pend_v;
        if (i_eod) begin
          push_l   = 1'b1;
          clr_pend = 1'b1;
          adv      = 1'b1;
          state_d  = nxt[6] ? WAIT_SPACE : FLUSH;
        end else begin
          ld_pend = 1'b1;
          winc    = 1'b1;
          if (wcnt == CW'(MAX_WORDS - 1)) begin
            set_err = 1'b1;
            dclr    = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The truncating word waits one cycle in pending to get its last flag.
        push     = pend_v;
        push_l   = 1'b1;
        clr_pend = 1'b1;
        if (i_eod || dcnt == DW'(DRAIN_MAX - 1)) begin
          set_err = ~i_eod;
          adv     = 1'b1;
          state_d = nxt[6] ? WAIT_SPACE : FLUSH;
        end else begin
          dinc = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == '0 && !pend_v) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idx    <= '0;
      mask_q <= '0;
      pend_v <= 1'b0;
      pend_d <= '0;
      wcnt   <= '0;
      dcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (ld_first) begin
        idx    <= first[5:0];
        mask_q <= i_src_mask;
      end else if (adv) begin
        idx <= nxt[5:0];
      end
      if (clr_pend) begin
        pend_v <= 1'b0;
      end else if (ld_pend) begin
        pend_v <= 1'b1;
        pend_d <= i_frame;
      end
      if (wclr)
        wcnt <= '0;
      else if (winc)
        wcnt <= wcnt + CW'(1);
      if (dclr)
        dcnt <= '0;
      else if (dinc)
        dcnt <= dcnt + DW'(1);
      if (ld_first)
        err_q <= 1'b0;
      else if (set_err)
        err_q <= 1'b1;
    end
  end

  assign valid = (cnt != '0);
  assign pop   = valid && stream.data_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      assert (!(push && !pop && cnt == (AW+1)'(FIFO_DEPTH)));
      if (push) begin
        mem_d[wp] <= pend_d;
        mem_t[wp] <= cur_id;
        mem_l[wp] <= push_l;
        wp        <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign stream.data       = valid ? mem_d[rp] : '0;
  assign stream.tag        = valid ? mem_t[rp] : '0;
  assign stream.last       = valid ? mem_l[rp] : 1'b0;
  assign stream.data_valid = valid;

  assign o_select = sel;
  assign o_done   = done;
  assign o_busy   = (state != IDLE) && !done;
  assign o_halt   = o_busy;
  assign o_error  = err_q;
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: scripted writers, stream scoreboard,
// table vectors, random dumps and reset/timing corner sequences.
module tb_debug_dump_sequencer;
  localparam int MAX_WORDS = 3;
  localparam int DRAIN_MAX = 15;
  localparam logic [5:0] NONE = 6'h3f;

  typedef struct {
    logic [2:0] m;
    int         words;
    int         pc_words;
    bit         eod;
    int         rm;
    int         stall;
    int         poke;
    int         exp_n;
    bit         exp_err;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mask  = '0;
  logic [5:0]  sel;
  logic [31:0] frame = '0;
  logic        eod   = 1'b0;
  logic        halt, busy, done, err;

  debug_dump_sequencer_if sif();

  debug_dump_sequencer dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_src_mask (mask),
    .o_select   (sel),
    .i_frame    (frame),
    .i_eod      (eod),
    .o_halt     (halt),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (err),
    .stream     (sif)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  int          sel_seen = 0;
  int          rmode    = 0;
  int          stall_left = 0;
  bit          track    = 1'b0;
  int          nw [64];
  bit          has_eod [64];
  logic [31:0] seed = '0;
  logic [38:0] exp_q [$];
  logic [5:0]  exp_sel [$];
  bit          exp_err;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int id, input int k);
    if (id == 34 && k == 0) return 32'h00400010;
    return 32'(id) * 32'h11 + (32'(k) << 20) + seed;
  endfunction

  // Reference: enabled sources in order, each keeps at most MAX_WORDS words.
  task automatic build_model(input logic [2:0] m);
    int cnt;
    bit en;
    exp_q.delete();
    exp_sel.delete();
    exp_err = 1'b0;
    for (int id = 0; id < 44; id++) begin
      en = (id < 32) ? m[0] : (id == 34) ? m[1] : (id >= 36) ? m[2] : 1'b0;
      if (en) begin
        exp_sel.push_back(6'(id));
        cnt = (nw[id] < MAX_WORDS) ? nw[id] : MAX_WORDS;
        for (int k = 0; k < cnt; k++)
          exp_q.push_back({(k == cnt - 1), 6'(id), word_of(id, k)});
        if (nw[id] >= MAX_WORDS) exp_err = 1'b1;
      end
    end
  endtask

  int         w_id = 0;
  int         w_pos = 0;
  bit         w_act = 1'b0;
  logic [5:0] prev_sel = 6'h3f;

  always @(negedge clk) begin
    eod   = 1'b0;
    frame = $urandom;
    if (w_act) begin
      if (w_pos < nw[w_id]) begin
        frame = word_of(w_id, w_pos);
      end else if (has_eod[w_id]) begin
        eod   = 1'b1;
        w_act = 1'b0;
      end
      w_pos++;
    end
    if (sel != NONE) begin
      w_act = 1'b1;
      w_id  = int'(sel);
      w_pos = 0;
      sel_seen++;
      if (track) begin
        check("select_one_cycle", prev_sel, NONE);
        if (exp_sel.size() == 0) check("select_extra", sel, NONE);
        else check("select_id", sel, exp_sel.pop_front());
      end
    end
    prev_sel = sel;
  end

  bit          hold_pend = 1'b0;
  logic [38:0] held = '0;

  always @(negedge clk) begin
    logic        r;
    logic [38:0] cur;
    case (rmode)
      0: r = 1'b1;
      1: r = 1'($urandom_range(0, 1));
      default: begin
        r = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    endcase
    sif.data_ready = r;
    cur = {sif.last, sif.tag, sif.data};
    if (track) begin
      if (hold_pend) begin
        check("hold_valid", sif.data_valid, 1);
        check("hold_word", cur, held);
      end
      if (sif.data_valid && r) begin
        n_pop++;
        if (exp_q.size() == 0) check("stream_extra", 1, 0);
        else check("stream_word", cur, exp_q.pop_front());
      end
    end
    hold_pend = track && sif.data_valid && !r;
    held      = cur;
  end

  task automatic run_dump(input logic [2:0] m, input int rm, input int stall,
                          input int poke, output int dcyc);
    bit halt_ok;
    halt_ok = 1'b1;
    build_model(m);
    rmode      = rm;
    stall_left = stall;
    n_pop      = 0;
    sel_seen   = 0;
    track      = 1'b1;
    mask       = m;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc  = 1;
    while (!done && dcyc < 4000) begin
      if (!halt || !busy) halt_ok = 1'b0;
      if (rm == 2 && dcyc == 35) check("wait_space_stall", sel_seen, 2);
      start = (dcyc == poke);
      if (dcyc == poke) mask = 3'b111;
      @(negedge clk);
      dcyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("done_busy_halt", {busy, halt}, 0);
    check("error_flag", err, exp_err);
    check("stream_left", exp_q.size(), 0);
    check("select_left", exp_sel.size(), 0);
    check("halt_held", halt_ok, 1);
    @(negedge clk);
    check("done_pulse", {done, busy}, 0);
    track = 1'b0;
  endtask

  initial begin
    vec_t vt [7];
    int   dc;

    vt[0] = '{3'b010, 1, 1, 1'b1, 0, 0,  0, 1,  1'b0};
    vt[1] = '{3'b001, 1, 1, 1'b1, 0, 0, 10, 32, 1'b0};
    vt[2] = '{3'b100, 3, 3, 1'b1, 2, 40, 0, 24, 1'b1};
    vt[3] = '{3'b110, 1, 5, 1'b1, 0, 0,  0, 11, 1'b1};
    vt[4] = '{3'b010, 1, 5, 1'b0, 0, 0,  0, 3,  1'b1};
    vt[5] = '{3'b111, 2, 2, 1'b1, 1, 0,  0, 82, 1'b0};
    vt[6] = '{3'b000, 1, 1, 1'b1, 0, 0,  0, 0,  1'b0};

    for (int id = 0; id < 64; id++) begin
      nw[id]      = 1;
      has_eod[id] = 1'b1;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state",
          {sel, busy, halt, done, err, sif.data_valid, sif.last,
           sif.tag, sif.data},
          {NONE, 6'b0, 6'b0, 32'b0});
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      seed = '0;
      for (int id = 0; id < 64; id++) begin
        nw[id]      = vt[v].words;
        has_eod[id] = vt[v].eod;
      end
      nw[34] = vt[v].pc_words;
      run_dump(vt[v].m, vt[v].rm, vt[v].stall, vt[v].poke, dc);
      check("vec_word_count", n_pop, vt[v].exp_n);
      check("vec_error", err, vt[v].exp_err);
      if (v == 4) check("drain_timeout_cycle", dc, 2 + MAX_WORDS + DRAIN_MAX + 1);
      if (v == 6) check("empty_mask_done_cycle", dc, 1);
    end

    seed = '0;
    for (int id = 0; id < 64; id++) begin
      nw[id]      = 1;
      has_eod[id] = 1'b1;
    end
    track = 1'b0;
    rmode = 0;
    mask  = 3'b001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    while (sel != 6'd7 && dc < 500) begin
      @(negedge clk);
      dc++;
    end
    check("reached_gpr7", sel, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_dump", {busy, halt, done, sif.data_valid, sel, err},
          {4'b0, NONE, 1'b0});
    @(negedge clk);
    run_dump(3'b001, 0, 0, 0, dc);
    check("restart_word_count", n_pop, 32);

    for (int it = 0; it < 6; it++) begin
      seed = $urandom;
      for (int id = 0; id < 64; id++) begin
        nw[id]      = $urandom_range(0, 5);
        has_eod[id] = (nw[id] < MAX_WORDS) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      run_dump(3'($urandom_range(1, 7)), 1, 0, 0, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
